// File: rtl/gray_stim_seq_pkg.sv
// Shared types and helpers for the Gray-code stimulus sequencer.
// Holds the FSM state type, the sweep length and the binary-to-Gray conversion.
package gray_stim_seq_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  localparam int         NSTEPS   = 16;
  localparam logic [3:0] LAST_IDX = 4'(NSTEPS - 1);

  function automatic logic [3:0] bin2gray(input logic [3:0] bin);
    return bin ^ (bin >> 1);
  endfunction

endpackage

// File: rtl/gray_stim_seq_if.sv
// Control and stimulus bundle between the sequencer and its driver/consumer.
// master drives start/stop/loop/dwell and observes the gate stimulus; slave is the sequencer.
interface gray_stim_seq_if #(
  parameter int DWELL_W = 8
);

  logic               start;
  logic               stop;
  logic               loop;
  logic [DWELL_W-1:0] dwell;
  logic               a;
  logic               b;
  logic               c;
  logic               d;
  logic [3:0]         step_idx;
  logic               step_strobe;
  logic               busy;
  logic               done;

  modport master (
    output start, stop, loop, dwell,
    input  a, b, c, d, step_idx, step_strobe, busy, done
  );

  modport slave (
    input  start, stop, loop, dwell,
    output a, b, c, d, step_idx, step_strobe, busy, done
  );

endinterface

// File: rtl/gray_stim_seq_dwell_timer.sv
// Loadable up-counter: load forces the count to 1, en increments, tc_o flags count == limit.
// Registered count, combinational terminal-count compare; no backpressure.
module gray_stim_seq_dwell_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_i,
  input  logic         en_i,
  input  logic [W-1:0] limit_i,
  output logic         tc_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = W'(1);
    end else if (en_i) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc_o = (cnt_q == limit_i);

endmodule

// File: rtl/gray_stim_seq.sv
// Steps {d,a,b,c} through the 16 reflected Gray codes, holding each for a latched dwell.
// All outputs registered: first code and strobe appear the cycle after start is sampled.
module gray_stim_seq
  import gray_stim_seq_pkg::*;
#(
  parameter int DWELL_W = 8
) (
  input logic            clk,
  input logic            rst,
  gray_stim_seq_if.slave bus
);

  state_e             state_q, state_d;
  logic [3:0]         idx_q, idx_d;
  logic [3:0]         code_q, code_d;
  logic               strobe_q, strobe_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               loop_q, loop_d;
  logic [DWELL_W-1:0] dwell_q, dwell_d;
  logic               tmr_load;
  logic               tmr_en;
  logic               tmr_tc;
  logic               start_go;
  logic               last_step;

  assign start_go  = bus.start && !bus.stop;
  assign last_step = (idx_q == LAST_IDX);

  gray_stim_seq_dwell_timer #(
    .W (DWELL_W)
  ) u_dwell_timer (
    .clk     (clk),
    .rst     (rst),
    .load_i  (tmr_load),
    .en_i    (tmr_en),
    .limit_i (dwell_q),
    .tc_o    (tmr_tc)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      idx_q    <= '0;
      code_q   <= '0;
      strobe_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      loop_q   <= 1'b0;
      dwell_q  <= '0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      code_q   <= code_d;
      strobe_q <= strobe_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      loop_q   <= loop_d;
      dwell_q  <= dwell_d;
    end
  end

  // stop wins over an advance landing on the same edge.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (start_go) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (bus.stop) begin
          state_d = ST_IDLE;
        end else if (tmr_tc && last_step && !loop_q) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    idx_d    = idx_q;
    code_d   = code_q;
    strobe_d = 1'b0;
    done_d   = 1'b0;
    loop_d   = loop_q;
    dwell_d  = dwell_q;
    tmr_load = 1'b0;
    tmr_en   = 1'b0;
    busy_d   = (state_d == ST_RUN);
    case (state_q)
      ST_IDLE: begin
        if (start_go) begin
          dwell_d  = (bus.dwell == '0) ? DWELL_W'(1) : bus.dwell;
          loop_d   = bus.loop;
          idx_d    = '0;
          code_d   = '0;
          strobe_d = 1'b1;
          tmr_load = 1'b1;
        end
      end
      ST_RUN: begin
        if (!bus.stop) begin
          if (tmr_tc) begin
            if (last_step && !loop_q) begin
              done_d = 1'b1;
            end else begin
              // 4-bit index wraps 15 -> 0 naturally in loop mode.
              idx_d    = idx_q + 4'd1;
              code_d   = bin2gray(idx_q + 4'd1);
              strobe_d = 1'b1;
              tmr_load = 1'b1;
            end
          end else begin
            tmr_en = 1'b1;
          end
        end
      end
      default: begin
        idx_d = idx_q;
      end
    endcase
  end

  assign bus.d           = code_q[3];
  assign bus.a           = code_q[2];
  assign bus.b           = code_q[1];
  assign bus.c           = code_q[0];
  assign bus.step_idx    = idx_q;
  assign bus.step_strobe = strobe_q;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;

endmodule

// File: tb/tb_gray_stim_seq.sv
// Directed bench for gray_stim_seq: cycle-level arithmetic model plus literal expectations.
module tb_gray_stim_seq;

  localparam int DW     = 8;
  localparam int NSTEPS = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  gray_stim_seq_if #(.DWELL_W(DW)) bus ();

  gray_stim_seq #(.DWELL_W(DW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: time since the sweep's first code, divided by the dwell, gives the index.
  bit         m_run;
  int         m_k;
  int         m_D;
  bit         m_loop;
  logic [3:0] m_idx;
  bit         m_strobe;
  bit         m_done;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_run    <= 1'b0;
      m_k      <= 0;
      m_D      <= 0;
      m_loop   <= 1'b0;
      m_idx    <= '0;
      m_strobe <= 1'b0;
      m_done   <= 1'b0;
    end else begin
      m_strobe <= 1'b0;
      m_done   <= 1'b0;
      if (!m_run) begin
        if (bus.start && !bus.stop) begin
          m_run    <= 1'b1;
          m_D      <= (bus.dwell == 0) ? 1 : int'(bus.dwell);
          m_loop   <= bus.loop;
          m_k      <= 0;
          m_idx    <= '0;
          m_strobe <= 1'b1;
        end
      end else if (bus.stop) begin
        m_run <= 1'b0;
      end else begin
        m_k <= m_k + 1;
        if (!m_loop && ((m_k + 1) / m_D) >= NSTEPS) begin
          m_run  <= 1'b0;
          m_done <= 1'b1;
          m_idx  <= 4'(NSTEPS - 1);
        end else begin
          m_idx    <= 4'(((m_k + 1) / m_D) % NSTEPS);
          m_strobe <= ((m_k + 1) % m_D) == 0;
        end
      end
    end
  end

  logic [3:0]  exp_code;
  logic [3:0]  act_code;
  logic [10:0] exp_v;
  logic [10:0] act_v;
  assign exp_code = m_idx ^ (m_idx >> 1);
  assign act_code = {bus.d, bus.a, bus.b, bus.c};
  assign exp_v    = {exp_code, m_idx, m_strobe, m_run, m_done};
  assign act_v    = {act_code, bus.step_idx, bus.step_strobe, bus.busy, bus.done};

  int         cyc = 0;
  int         n_strobe;
  int         n_done;
  int         first_strobe;
  int         done_cyc;
  int         wrap_seen;
  logic [3:0] prev_code;
  logic [3:0] prev_idx;
  logic [3:0] codes[$];

  always @(negedge clk) begin
    cyc++;
    check("cycle", int'(act_v), int'(exp_v));
    if (bus.step_strobe) begin
      n_strobe++;
      if (first_strobe < 0) first_strobe = cyc;
      codes.push_back(act_code);
      if (m_k > 0) begin
        check("one_bit_step", $countones(act_code ^ prev_code), 1);
        if (prev_idx == 4'd15 && bus.step_idx == 4'd0) wrap_seen++;
      end
      prev_code = act_code;
      prev_idx  = bus.step_idx;
    end
    if (bus.done) begin
      n_done++;
      done_cyc = cyc;
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic clear_stats();
    n_strobe     = 0;
    n_done       = 0;
    first_strobe = -1;
    done_cyc     = -1;
    wrap_seen    = 0;
    codes.delete();
  endtask

  task automatic launch(input int dw, input bit lp);
    bus.dwell = 8'(dw);
    bus.loop  = lp;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  task automatic wait_done(input int limit);
    int i = 0;
    while (n_done == 0 && i < limit) begin
      tick();
      i++;
    end
    check("done_seen", int'(n_done > 0), 1);
  endtask

  logic [3:0] gray_tab [16] = '{4'h0, 4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4,
                                4'hC, 4'hD, 4'hF, 4'hE, 4'hA, 4'hB, 4'h9, 4'h8};

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1);
  end

  initial begin
    int         bad;
    int         distinct;
    bit         seen [16];
    logic [3:0] frozen_idx;

    rst       = 1'b1;
    bus.start = 1'b0;
    bus.stop  = 1'b0;
    bus.loop  = 1'b0;
    bus.dwell = '0;
    clear_stats();
    tick(2);
    rst = 1'b0;
    tick();
    check("reset_state", int'(act_v), 0);

    // Asynchronous reset in the middle of a dwell=3 sweep.
    launch(3, 1'b0);
    tick(10);
    @(posedge clk);
    #2;
    check("busy_before_rst", int'(bus.busy), 1);
    rst = 1'b1;
    #1;
    check("rst_async_clear", int'(act_v), 0);
    tick(2);
    rst = 1'b0;
    clear_stats();
    tick(5);
    check("no_strobe_after_rst", n_strobe, 0);

    // dwell=1 single sweep: full Gray table, one code per cycle.
    clear_stats();
    launch(1, 1'b0);
    wait_done(40);
    check("d1_strobes", n_strobe, 16);
    check("d1_span", done_cyc - first_strobe, 16);
    check("d1_ncodes", codes.size(), 16);
    bad = 0;
    distinct = 0;
    foreach (seen[i]) seen[i] = 1'b0;
    for (int i = 0; i < 16 && i < codes.size(); i++) begin
      if (codes[i] !== gray_tab[i]) bad++;
      if (!seen[codes[i]]) distinct++;
      seen[codes[i]] = 1'b1;
    end
    check("d1_gray_table", bad, 0);
    check("d1_all_codes_covered", distinct, 16);
    check("d1_last_code", int'(act_code), 8);
    tick(3);
    check("d1_single_done", n_done, 1);

    // dwell=0 behaves as dwell=1; dwell=4 stretches the sweep to 64 cycles.
    clear_stats();
    launch(0, 1'b0);
    wait_done(40);
    check("d0_strobes", n_strobe, 16);
    check("d0_span", done_cyc - first_strobe, 16);
    clear_stats();
    launch(4, 1'b0);
    wait_done(100);
    check("d4_strobes", n_strobe, 16);
    check("d4_span", done_cyc - first_strobe, 64);

    // Loop mode with dwell=2, then stop.
    clear_stats();
    launch(2, 1'b1);
    for (int i = 0; i < 200 && n_strobe < 40; i++) tick();
    check("loop_40_codes", int'(n_strobe >= 40), 1);
    check("loop_no_done", n_done, 0);
    check("loop_wraps", wrap_seen, 2);
    bus.stop = 1'b1;
    tick();
    bus.stop   = 1'b0;
    frozen_idx = m_idx;
    check("stop_busy_low", int'(bus.busy), 0);
    bad = n_strobe;
    tick(4);
    check("stop_idx_frozen", int'(bus.step_idx), int'(frozen_idx));
    check("stop_no_strobe", n_strobe, bad);
    check("stop_no_done", n_done, 0);

    // start re-pulsed mid-sweep with a new dwell is ignored.
    clear_stats();
    launch(2, 1'b0);
    tick(5);
    bus.dwell = 8'd7;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    wait_done(100);
    check("restart_ignored_span", done_cyc - first_strobe, 32);
    check("restart_ignored_strobes", n_strobe, 16);

    // start and stop together in IDLE keep the sequencer idle.
    bus.start = 1'b1;
    bus.stop  = 1'b1;
    tick(3);
    check("start_stop_idle_busy", int'(bus.busy), 0);
    check("start_stop_no_strobe", n_strobe, 16);
    bus.start = 1'b0;
    bus.stop  = 1'b0;
    tick();

    // Held start relaunches on the edge after done.
    clear_stats();
    bus.dwell = 8'd1;
    bus.loop  = 1'b0;
    bus.start = 1'b1;
    wait_done(40);
    tick();
    check("held_start_strobe", int'(bus.step_strobe), 1);
    check("held_start_busy", int'(bus.busy), 1);
    check("held_start_idx", int'(bus.step_idx), 0);
    bus.start = 1'b0;
    bus.stop  = 1'b1;
    tick();
    bus.stop = 1'b0;
    tick(2);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
